// File: rtl/trap_unit.sv
// trap_unit -- trap arbiter between the pipeline stages and the Control Unit.
//
// Collects per-stage exceptions, MRET and prioritised interrupt lines. In IDLE
// it picks the oldest event, registers epc/cause/tval/destination and raises
// trap_req until the Control Unit acknowledges. After the ack it spends one
// FLUSH cycle ignoring events while the pipeline refills.
//
// State table
//   state | meaning
//   IDLE  | watching for events; capture and squash happen here
//   PEND  | trap_req high, captured values frozen, waiting for trap_ack
//   FLUSH | one cycle after ack; events dropped, outputs hold
//
// Ports
//   clk, rst_n    core clock, asynchronous active-low reset
//   stage_pc      PC of stage i at [i*XLEN +: XLEN] (0 = youngest)
//   stage_valid   stage i holds a real instruction
//   exc_flag      stage i raises an exception
//   exc_cause     5-bit exception code of stage i
//   exc_tval      trap value of stage i
//   mret          MRET valid in stage MRET_STAGE
//   irq_pending   masked pending interrupts, higher index wins
//   mepc, mtvec   CSR values (mtvec[1:0]==01 selects vectored mode)
//   trap_ack      Control Unit has inserted the trap
//   trap_req      trap pending toward the Control Unit
//   trap_is_mret  pending trap is an MRET
//   trap_addr     redirect target
//   trap_epc      faulting/interrupted PC
//   trap_cause    mcause value (MSB = interrupt)
//   trap_val      mtval value
//   squash        kill stage i (capture cycle only)
//   busy          state != IDLE
module trap_unit #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 3,
  parameter int NUM_IRQ    = 16,
  parameter int MRET_STAGE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_STAGES*XLEN-1:0] stage_pc,
  input  logic [NUM_STAGES-1:0]      stage_valid,
  input  logic [NUM_STAGES-1:0]      exc_flag,
  input  logic [NUM_STAGES*5-1:0]    exc_cause,
  input  logic [NUM_STAGES*XLEN-1:0] exc_tval,
  input  logic                       mret,
  input  logic [NUM_IRQ-1:0]         irq_pending,
  input  logic [XLEN-1:0]            mepc,
  input  logic [XLEN-1:0]            mtvec,
  input  logic                       trap_ack,
  output logic                       trap_req,
  output logic                       trap_is_mret,
  output logic [XLEN-1:0]            trap_addr,
  output logic [XLEN-1:0]            trap_epc,
  output logic [XLEN-1:0]            trap_cause,
  output logic [XLEN-1:0]            trap_val,
  output logic [NUM_STAGES-1:0]      squash,
  output logic                       busy
);

  localparam int IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

  state_t state, state_nxt;

  logic                  sel_exc, sel_mret;
  logic [XLEN-1:0]       sel_pc, sel_cause, sel_tval;
  logic [NUM_STAGES-1:0] sel_squash;
  logic                  irq_any, take_irq, ev;
  logic [IRQ_W-1:0]      irq_idx;
  logic [XLEN-1:0]       irq_cause, base, nxt_addr;

  // Scan stages youngest to oldest so the oldest qualifying stage overrides.
  // Within one stage the exception branch is tried first, so it beats MRET.
  always_comb begin
    sel_exc    = 1'b0;
    sel_mret   = 1'b0;
    sel_pc     = '0;
    sel_cause  = '0;
    sel_tval   = '0;
    sel_squash = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage_valid[k] && exc_flag[k]) begin
        sel_exc   = 1'b1;
        sel_mret  = 1'b0;
        sel_pc    = stage_pc[k*XLEN +: XLEN];
        sel_cause = XLEN'(exc_cause[k*5 +: 5]);
        sel_tval  = exc_tval[k*XLEN +: XLEN];
        for (int i = 0; i < NUM_STAGES; i++) sel_squash[i] = (i <= k);
      end else if ((k == MRET_STAGE) && mret) begin
        sel_exc   = 1'b0;
        sel_mret  = 1'b1;
        sel_pc    = stage_pc[k*XLEN +: XLEN];
        sel_cause = '0;
        sel_tval  = '0;
        for (int i = 0; i < NUM_STAGES; i++) sel_squash[i] = (i <= k);
      end
    end
  end

  always_comb begin
    irq_any = 1'b0;
    irq_idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_pending[i]) begin
        irq_any = 1'b1;
        irq_idx = IRQ_W'(i);
      end
    end
    irq_cause              = '0;
    irq_cause[XLEN-1]      = 1'b1;
    irq_cause[IRQ_W-1:0]   = irq_idx;
  end

  // Interrupts are only taken at a real instruction boundary in Fetch.
  assign take_irq = !(sel_exc || sel_mret) && stage_valid[0] && irq_any;
  // rst_n gates ev so squash stays low while reset is asserted.
  assign ev       = rst_n && (state == IDLE) && (sel_exc || sel_mret || take_irq);

  assign base = {mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    nxt_addr = base;
    if (sel_mret)                          nxt_addr = mepc;
    else if (take_irq && mtvec[1:0] == 2'b01) nxt_addr = base + (XLEN'(irq_idx) << 2);
  end

  always_comb begin
    squash = '0;
    if (ev) squash = take_irq ? NUM_STAGES'(1) : sel_squash;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ev) state_nxt = PEND;
      PEND:    if (trap_ack) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_is_mret <= 1'b0;
      trap_addr    <= '0;
      trap_epc     <= '0;
      trap_cause   <= '0;
      trap_val     <= '0;
    end else if (ev) begin
      trap_is_mret <= sel_mret;
      trap_addr    <= nxt_addr;
      trap_epc     <= take_irq ? stage_pc[XLEN-1:0] : sel_pc;
      trap_cause   <= take_irq ? irq_cause : sel_cause;
      trap_val     <= take_irq ? '0 : sel_tval;
    end
  end

  assign trap_req = (state == PEND);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_trap_unit.sv
module tb_trap_unit;

  localparam int XLEN = 32;
  localparam int NS   = 3;
  localparam int NI   = 16;
  localparam int MS   = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NS*XLEN-1:0] stage_pc = '0;
  logic [NS-1:0]   stage_valid = '0;
  logic [NS-1:0]   exc_flag = '0;
  logic [NS*5-1:0] exc_cause = '0;
  logic [NS*XLEN-1:0] exc_tval = '0;
  logic            mret = 1'b0;
  logic [NI-1:0]   irq_pending = '0;
  logic [XLEN-1:0] mepc = '0;
  logic [XLEN-1:0] mtvec = '0;
  logic            trap_ack = 1'b0;
  logic            trap_req, trap_is_mret, busy;
  logic [XLEN-1:0] trap_addr, trap_epc, trap_cause, trap_val;
  logic [NS-1:0]   squash;

  int total = 0;
  int bad   = 0;

  trap_unit #(.XLEN(XLEN), .NUM_STAGES(NS), .NUM_IRQ(NI), .MRET_STAGE(MS)) dut (
    .clk(clk), .rst_n(rst_n), .stage_pc(stage_pc), .stage_valid(stage_valid),
    .exc_flag(exc_flag), .exc_cause(exc_cause), .exc_tval(exc_tval), .mret(mret),
    .irq_pending(irq_pending), .mepc(mepc), .mtvec(mtvec), .trap_ack(trap_ack),
    .trap_req(trap_req), .trap_is_mret(trap_is_mret), .trap_addr(trap_addr),
    .trap_epc(trap_epc), .trap_cause(trap_cause), .trap_val(trap_val),
    .squash(squash), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: kind 0 none, 1 exception, 2 mret, 3 interrupt.
  function automatic void find_event(output int kind, output int k, output int idx);
    kind = 0; k = 0; idx = 0;
    for (int s = NS - 1; s >= 0; s--) begin
      if (kind == 0) begin
        if (stage_valid[s] && exc_flag[s]) begin kind = 1; k = s; end
        else if (s == MS && mret)          begin kind = 2; k = s; end
      end
    end
    if (kind == 0 && stage_valid[0] && irq_pending != 0)
      for (int i = NI - 1; i >= 0; i--)
        if (kind == 0 && irq_pending[i]) begin kind = 3; idx = i; end
  endfunction

  logic            m_req, m_flush, m_mret;
  logic [XLEN-1:0] m_addr, m_epc, m_cause, m_val;

  always @(posedge clk or negedge rst_n) begin
    int kind, k, idx;
    if (!rst_n) begin
      m_req = 0; m_flush = 0; m_mret = 0;
      m_addr = 0; m_epc = 0; m_cause = 0; m_val = 0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_req) begin
      if (trap_ack) begin m_req = 0; m_flush = 1; end
    end else begin
      find_event(kind, k, idx);
      if (kind != 0) begin
        m_req  = 1;
        m_mret = (kind == 2);
        if (kind == 3) begin
          m_epc   = stage_pc[31:0];
          m_cause = 32'h8000_0000 + idx;
          m_val   = 0;
          m_addr  = (mtvec & ~32'd3) + ((mtvec[1:0] == 2'b01) ? 32'(4 * idx) : 32'd0);
        end else begin
          m_epc   = stage_pc[k*XLEN +: XLEN];
          m_cause = (kind == 1) ? 32'(exc_cause[k*5 +: 5]) : 32'd0;
          m_val   = (kind == 1) ? exc_tval[k*XLEN +: XLEN] : 32'd0;
          m_addr  = (kind == 2) ? mepc : (mtvec & ~32'd3);
        end
      end
    end
  end

  always @(negedge clk) begin
    int kind, k, idx;
    logic [31:0] exp_sq;
    if (rst_n) begin
      exp_sq = 0;
      if (!m_req && !m_flush) begin
        find_event(kind, k, idx);
        if (kind == 1 || kind == 2) exp_sq = (32'd1 << (k + 1)) - 1;
        else if (kind == 3)         exp_sq = 1;
      end
      chk("m_squash",  32'(squash), exp_sq);
      chk("m_req",     32'(trap_req), 32'(m_req));
      chk("m_busy",    32'(busy), 32'(m_req | m_flush));
      chk("m_is_mret", 32'(trap_is_mret), 32'(m_mret));
      chk("m_addr",    trap_addr, m_addr);
      chk("m_epc",     trap_epc, m_epc);
      chk("m_cause",   trap_cause, m_cause);
      chk("m_val",     trap_val, m_val);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic finish_trap();
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    @(negedge clk);
    chk("flush_req", 32'(trap_req), 0);
    chk("flush_busy", 32'(busy), 1);
    step();
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_req", 32'(trap_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", trap_addr, 0);
    chk("rst_squash", 32'(squash), 0);
    step();
    rst_n = 1'b1;

    // Illegal instruction at stage 1
    step();
    stage_valid = 3'b111;
    stage_pc    = {32'h0000_0200, 32'h0000_0100, 32'h0000_00fc};
    exc_flag    = 3'b010;
    exc_cause   = {5'd0, 5'd2, 5'd0};
    exc_tval    = {32'h0, 32'h13, 32'h0};
    mtvec       = 32'h0000_1000;
    @(negedge clk);
    chk("ill_squash", 32'(squash), 32'b011);
    chk("ill_req0", 32'(trap_req), 0);
    step();
    exc_flag = '0;
    @(negedge clk);
    chk("ill_req", 32'(trap_req), 1);
    chk("ill_epc", trap_epc, 32'h100);
    chk("ill_cause", trap_cause, 32'd2);
    chk("ill_val", trap_val, 32'h13);
    chk("ill_addr", trap_addr, 32'h1000);
    finish_trap();

    // Priority: stage 2 beats stage 1 and irq
    step();
    exc_flag    = 3'b110;
    exc_cause   = {5'd5, 5'd3, 5'd0};
    irq_pending = 16'h0080;
    @(negedge clk);
    chk("pri_squash", 32'(squash), 32'b111);
    step();
    exc_flag = '0; irq_pending = '0;
    @(negedge clk);
    chk("pri_epc", trap_epc, 32'h200);
    chk("pri_cause", trap_cause, 32'd5);
    finish_trap();

    // Vectored interrupt
    step();
    stage_valid = 3'b001;
    stage_pc    = {32'h0000_0200, 32'h0000_0180, 32'h0000_00f0};
    irq_pending = 16'h0880;
    mtvec       = 32'h8000_0001;
    @(negedge clk);
    chk("irq_squash", 32'(squash), 32'b001);
    step();
    irq_pending = '0;
    @(negedge clk);
    chk("irq_cause", trap_cause, 32'h8000_000B);
    chk("irq_addr", trap_addr, 32'h8000_002C);
    chk("irq_epc", trap_epc, 32'h0000_00f0);
    finish_trap();

    // Ack outside PEND is ignored
    step();
    trap_ack = 1'b1;
    @(negedge clk);
    chk("ack_idle_busy", 32'(busy), 0);
    step();
    trap_ack = 1'b0;
    @(negedge clk);
    chk("ack_idle_req", 32'(trap_req), 0);

    // MRET, then irq held through FLUSH
    step();
    stage_valid = 3'b000;
    mret = 1'b1;
    mepc = 32'h0000_0400;
    @(negedge clk);
    chk("mret_squash", 32'(squash), 32'b011);
    step();
    mret = 1'b0;
    @(negedge clk);
    chk("mret_flag", 32'(trap_is_mret), 1);
    chk("mret_addr", trap_addr, 32'h400);
    chk("mret_cause", trap_cause, 0);
    chk("mret_epc", trap_epc, 32'h180);
    trap_ack = 1'b1;
    irq_pending = 16'h0004;
    stage_valid = 3'b001;
    step();
    trap_ack = 1'b0;
    @(negedge clk);
    chk("mret_req_low", 32'(trap_req), 0);
    chk("flush_squash", 32'(squash), 0);
    step();
    @(negedge clk);
    chk("b2b_busy", 32'(busy), 0);
    chk("b2b_squash", 32'(squash), 32'b001);
    step();
    irq_pending = '0;
    @(negedge clk);
    chk("b2b_req", 32'(trap_req), 1);
    chk("b2b_cause", trap_cause, 32'h8000_0002);
    chk("b2b_addr", trap_addr, 32'h8000_0008);
    chk("b2b_mret", 32'(trap_is_mret), 0);
    finish_trap();

    // Hold: inputs churn during PEND
    step();
    stage_valid = 3'b111;
    stage_pc    = {32'h0000_0300, 32'h0000_0180, 32'h0000_00f0};
    exc_flag    = 3'b100;
    exc_cause   = {5'd7, 5'd0, 5'd0};
    exc_tval    = {32'hDEAD, 32'h0, 32'h0};
    mtvec       = 32'h0000_2000;
    step();
    for (int i = 0; i < 5; i++) begin
      exc_flag    = NS'(i + 1);
      exc_cause   = 15'(i * 4321);
      mtvec       = 32'h3001 + 32'(i * 4);
      irq_pending = 16'hFFFF;
      mret        = 1'b1;
      @(negedge clk);
      chk("hold_req", 32'(trap_req), 1);
      chk("hold_epc", trap_epc, 32'h300);
      chk("hold_cause", trap_cause, 32'd7);
      chk("hold_addr", trap_addr, 32'h2000);
      step();
    end
    exc_flag = '0; irq_pending = '0; mret = 1'b0;
    finish_trap();

    // Vectored address wraps
    step();
    stage_valid = 3'b001;
    mtvec       = 32'hFFFF_FFFD;
    irq_pending = 16'h8000;
    @(negedge clk);
    chk("wrap_squash", 32'(squash), 32'b001);
    step();
    irq_pending = '0;
    @(negedge clk);
    chk("wrap_addr", trap_addr, 32'h0000_0038);
    chk("wrap_cause", trap_cause, 32'h8000_000F);
    finish_trap();

    // Asynchronous reset mid-PEND
    step();
    stage_valid = 3'b111;
    exc_flag    = 3'b001;
    step();
    @(negedge clk);
    chk("rstp_req_before", 32'(trap_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstp_req", 32'(trap_req), 0);
    chk("rstp_busy", 32'(busy), 0);
    chk("rstp_epc", trap_epc, 0);
    chk("rstp_addr", trap_addr, 0);
    chk("rstp_squash", 32'(squash), 0);
    step();
    exc_flag = '0; stage_valid = '0;
    rst_n = 1'b1;
    step();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
